// File: rtl/l1_command_arbiter.sv
// Shares one L1 cache command port among NREQ requesters: requester 0 has fixed priority,
// the rest are served round-robin; tracks the cache busy handshake and reports completions.
module l1_command_arbiter #(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = 60,
    parameter int CMD_W   = 3,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*CMD_W-1:0]    req_cmd,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    output logic [NREQ-1:0]          req_ready,
    output logic                     cache_write,
    output logic [CMD_W-1:0]         cache_command,
    output logic [ADDR_W-1:0]        cache_address,
    input  logic                     cache_processing,
    output logic                     done_valid,
    output logic [ID_W-1:0]          done_id,
    output logic                     done_err,
    output logic [31:0]              issued_count
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CMD_W-1:0] CMD_LAST = CMD_W'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [ID_W-1:0]    rr_q;
    logic [ID_W-1:0]    id_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NREQ-1:0]    req_ready_q;
    logic               cache_write_q;
    logic [CMD_W-1:0]   cache_command_q;
    logic [ADDR_W-1:0]  cache_address_q;
    logic               done_valid_q;
    logic [ID_W-1:0]    done_id_q;
    logic               done_err_q;
    logic [31:0]        issued_count_q;

    logic [CMD_W-1:0]   cmd_arr  [NREQ];
    logic [ADDR_W-1:0]  addr_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign cmd_arr[gi]  = req_cmd[gi*CMD_W +: CMD_W];
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // Winner: requester 0 first, else the first valid one after rr_q within 1..NREQ-1.
    logic            win_any;
    logic [ID_W-1:0] win_id;
    int              idx;

    always_comb begin
        win_any = 1'b0;
        win_id  = '0;
        idx     = 0;
        if (req_valid[0]) begin
            win_any = 1'b1;
        end else begin
            for (int k = 1; k < NREQ; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NREQ) idx = idx - (NREQ - 1);
                if (!win_any && req_valid[ID_W'(idx)]) begin
                    win_any = 1'b1;
                    win_id  = ID_W'(idx);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            rr_q            <= ID_W'(NREQ - 1);
            id_q            <= '0;
            err_q           <= 1'b0;
            cnt_q           <= '0;
            req_ready_q     <= '0;
            cache_write_q   <= 1'b0;
            cache_command_q <= '0;
            cache_address_q <= '0;
            done_valid_q    <= 1'b0;
            done_id_q       <= '0;
            done_err_q      <= 1'b0;
            issued_count_q  <= '0;
        end else begin
            req_ready_q   <= '0;
            cache_write_q <= 1'b0;
            done_valid_q  <= 1'b0;
            done_id_q     <= '0;
            done_err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!cache_processing && win_any) begin
                        state_q     <= S_ISSUE;
                        id_q        <= win_id;
                        req_ready_q <= NREQ'(1) << win_id;
                        // Illegal commands are acknowledged but never reach the cache.
                        if (cmd_arr[win_id] <= CMD_LAST) begin
                            err_q           <= 1'b0;
                            cache_write_q   <= 1'b1;
                            cache_command_q <= cmd_arr[win_id];
                            cache_address_q <= addr_arr[win_id];
                            issued_count_q  <= issued_count_q + 32'd1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt_q <= '0;
                    if (err_q) begin
                        state_q      <= S_DONE;
                        done_valid_q <= 1'b1;
                        done_id_q    <= id_q;
                        done_err_q   <= 1'b1;
                    end else begin
                        state_q <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (cache_processing) begin
                        state_q <= S_WAIT_DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q      <= S_DONE;
                        done_valid_q <= 1'b1;
                        done_id_q    <= id_q;
                        done_err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!cache_processing) begin
                        state_q      <= S_DONE;
                        done_valid_q <= 1'b1;
                        done_id_q    <= id_q;
                        done_err_q   <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    if (id_q != '0) rr_q <= id_q;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign cache_write   = cache_write_q;
    assign cache_command = cache_command_q;
    assign cache_address = cache_address_q;
    assign done_valid    = done_valid_q;
    assign done_id       = done_id_q;
    assign done_err      = done_err_q;
    assign issued_count  = issued_count_q;

endmodule

// File: tb/tb_l1_command_arbiter.sv
// Directed bench for l1_command_arbiter with a small cache model that holds
// processing high for two cycles after each cache_write.
module tb_l1_command_arbiter;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 60;
    localparam int CMD_W  = 3;
    localparam int ID_W   = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*CMD_W-1:0]  req_cmd = '0;
    logic [NREQ*ADDR_W-1:0] req_addr = '0;
    logic [NREQ-1:0]        req_ready;
    logic                   cache_write;
    logic [CMD_W-1:0]       cache_command;
    logic [ADDR_W-1:0]      cache_address;
    logic                   cache_processing;
    logic                   done_valid;
    logic [ID_W-1:0]        done_id;
    logic                   done_err;
    logic [31:0]            issued_count;

    int tests_run    = 0;
    int tests_failed = 0;

    bit         model_en   = 1'b1;
    bit         force_proc = 1'b0;
    logic [1:0] busy_cnt   = 2'd0;

    l1_command_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .CMD_W(CMD_W), .ID_W(ID_W), .TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_cmd(req_cmd),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .cache_write(cache_write),
        .cache_command(cache_command),
        .cache_address(cache_address),
        .cache_processing(cache_processing),
        .done_valid(done_valid),
        .done_id(done_id),
        .done_err(done_err),
        .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cache_write && model_en) busy_cnt <= 2'd2;
        else if (busy_cnt != 2'd0)   busy_cnt <= busy_cnt - 2'd1;
    end
    assign cache_processing = force_proc | (busy_cnt != 2'd0);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int i, input logic [CMD_W-1:0] cmd, input logic [ADDR_W-1:0] addr);
        req_cmd[i*CMD_W +: CMD_W]    = cmd;
        req_addr[i*ADDR_W +: ADDR_W] = addr;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Leaves the caller at the negedge of the cycle in which req_ready is seen.
    task automatic wait_ready(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if ({req_ready, cache_write, cache_command, done_valid, done_id, done_err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got rdy=%b wr=%b cmd=%0d dv=%b id=%0d err=%b expected all 0",
                     req_ready, cache_write, cache_command, done_valid, done_id, done_err);
        end
        tests_run++;
        if (cache_address !== '0) begin
            tests_failed++; $display("FAIL reset_addr: got %0h expected 0", cache_address);
        end
        tests_run++;
        if (issued_count !== 32'd0) begin
            tests_failed++; $display("FAIL reset_count: got %0d expected 0", issued_count);
        end
        rst = 1'b1;
        @(negedge clk);
        $display("[TB] reset checked");
    endtask

    task automatic test_single_read();
        bit ok;
        set_req(1, 3'd0, 60'h40);
        req_valid = 3'b010;
        wait_ready(20, ok);
        req_valid = '0;
        tests_run++;
        if (!ok || req_ready !== 3'b010) begin
            tests_failed++; $display("FAIL t1_ready: got %b expected 010", req_ready);
        end
        tests_run++;
        if (cache_write !== 1'b1 || cache_command !== 3'd0 || cache_address !== 60'h40) begin
            tests_failed++;
            $display("FAIL t1_issue: got wr=%b cmd=%0d addr=%0h expected wr=1 cmd=0 addr=40",
                     cache_write, cache_command, cache_address);
        end
        tests_run++;
        if (issued_count !== 32'd1) begin
            tests_failed++; $display("FAIL t1_count: got %0d expected 1", issued_count);
        end
        @(negedge clk);
        tests_run++;
        if (cache_write !== 1'b0 || cache_address !== 60'h40) begin
            tests_failed++;
            $display("FAIL t1_hold: got wr=%b addr=%0h expected wr=0 addr=40", cache_write, cache_address);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (done_valid !== 1'b0) begin
            tests_failed++; $display("FAIL t1_early_done: got %b expected 0", done_valid);
        end
        @(negedge clk);
        tests_run++;
        if (done_valid !== 1'b1 || done_id !== 2'd1 || done_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL t1_done: got dv=%b id=%0d err=%b expected dv=1 id=1 err=0",
                     done_valid, done_id, done_err);
        end
        @(negedge clk);
        tests_run++;
        if (done_valid !== 1'b0) begin
            tests_failed++; $display("FAIL t1_done_pulse: got %b expected 0", done_valid);
        end
        $display("[TB] single read req1 addr=40 complete");
    endtask

    task automatic test_priority_rr();
        bit ok;
        int exp_id [6] = '{0, 0, 1, 2, 1, 2};
        logic [ADDR_W-1:0] exp_addr [NREQ] = '{60'h100, 60'h200, 60'h300};
        logic [NREQ-1:0] exp_rdy;
        apply_reset();
        set_req(0, 3'd2, 60'h100);
        set_req(1, 3'd1, 60'h200);
        set_req(2, 3'd3, 60'h300);
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_rdy = NREQ'(1 << exp_id[k]);
            wait_ready(40, ok);
            tests_run++;
            if (!ok || req_ready !== exp_rdy) begin
                tests_failed++;
                $display("FAIL t2_grant%0d: got %b expected %b", k, req_ready, exp_rdy);
            end
            tests_run++;
            if (cache_address !== exp_addr[exp_id[k]]) begin
                tests_failed++;
                $display("FAIL t2_addr%0d: got %0h expected %0h", k, cache_address, exp_addr[exp_id[k]]);
            end
            $display("[TB] grant %0d ready=%b", k, req_ready);
            if (k == 1) req_valid[0] = 1'b0;
            if (k == 5) req_valid = '0;
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (done_valid !== 1'b1 || done_id !== 2'd2 || done_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL t2_last_done: got dv=%b id=%0d err=%b expected dv=1 id=2 err=0",
                     done_valid, done_id, done_err);
        end
        tests_run++;
        if (issued_count !== 32'd6) begin
            tests_failed++; $display("FAIL t2_count: got %0d expected 6", issued_count);
        end
        @(negedge clk);
    endtask

    task automatic test_illegal_cmd();
        bit ok;
        set_req(1, 3'd6, 60'h55);
        req_valid = 3'b010;
        wait_ready(20, ok);
        req_valid = '0;
        tests_run++;
        if (!ok || req_ready !== 3'b010 || cache_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL t3_issue: got rdy=%b wr=%b expected rdy=010 wr=0", req_ready, cache_write);
        end
        tests_run++;
        if (issued_count !== 32'd6) begin
            tests_failed++; $display("FAIL t3_count: got %0d expected 6", issued_count);
        end
        @(negedge clk);
        tests_run++;
        if (done_valid !== 1'b1 || done_id !== 2'd1 || done_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL t3_done: got dv=%b id=%0d err=%b expected dv=1 id=1 err=1",
                     done_valid, done_id, done_err);
        end
        $display("[TB] illegal cmd 6 from req1 rejected");
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok;
        bit seen;
        model_en = 1'b0;
        set_req(2, 3'd1, 60'h77);
        req_valid = 3'b100;
        wait_ready(20, ok);
        req_valid = '0;
        tests_run++;
        if (!ok || cache_write !== 1'b1 || issued_count !== 32'd7) begin
            tests_failed++;
            $display("FAIL t4_issue: got wr=%b count=%0d expected wr=1 count=7", cache_write, issued_count);
        end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++; $display("FAIL t4_early_done: got done within 15 cycles expected none");
        end
        @(negedge clk);
        tests_run++;
        if (done_valid !== 1'b1 || done_id !== 2'd2 || done_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL t4_timeout: got dv=%b id=%0d err=%b expected dv=1 id=2 err=1",
                     done_valid, done_id, done_err);
        end
        $display("[TB] timeout on req2 reported");
        model_en = 1'b1;
        set_req(1, 3'd0, 60'h80);
        req_valid = 3'b010;
        wait_ready(20, ok);
        req_valid = '0;
        tests_run++;
        if (!ok || cache_write !== 1'b1 || issued_count !== 32'd8) begin
            tests_failed++;
            $display("FAIL t4_next_issue: got wr=%b count=%0d expected wr=1 count=8", cache_write, issued_count);
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (done_valid !== 1'b1 || done_id !== 2'd1 || done_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL t4_next_done: got dv=%b id=%0d err=%b expected dv=1 id=1 err=0",
                     done_valid, done_id, done_err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        set_req(1, 3'd0, 60'h90);
        req_valid = 3'b010;
        wait_ready(20, ok);
        req_valid = '0;
        repeat (2) @(negedge clk);
        set_req(2, 3'd0, 60'hA0);
        req_valid = 3'b100;
        rst = 1'b0;
        #1;
        tests_run++;
        if (cache_address !== '0 || cache_command !== '0 || issued_count !== 32'd0 ||
            {req_ready, cache_write, done_valid, done_id, done_err} !== '0) begin
            tests_failed++;
            $display("FAIL t5_async: got addr=%0h cmd=%0d count=%0d dv=%b expected all 0",
                     cache_address, cache_command, issued_count, done_valid);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_valid) seen = 1'b1;
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
        end
        req_valid = '0;
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++; $display("FAIL t5_stale_done: got done after reset expected none");
        end
        tests_run++;
        if (!ok || req_ready !== 3'b100 || cache_address !== 60'hA0) begin
            tests_failed++;
            $display("FAIL t5_grant: got rdy=%b addr=%0h expected rdy=100 addr=a0", req_ready, cache_address);
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (done_valid !== 1'b1 || done_id !== 2'd2) begin
            tests_failed++;
            $display("FAIL t5_done: got dv=%b id=%0d expected dv=1 id=2", done_valid, done_id);
        end
        $display("[TB] reset mid-command, req2 served after release");
        @(negedge clk);
    endtask

    task automatic test_busy_idle();
        bit seen;
        force_proc = 1'b1;
        set_req(1, 3'd4, 60'hB0);
        req_valid = 3'b010;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (req_ready != '0) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++; $display("FAIL t6_hold: got grant while busy expected none");
        end
        force_proc = 1'b0;
        @(negedge clk);
        req_valid = '0;
        tests_run++;
        if (req_ready !== 3'b010 || cache_write !== 1'b1 || cache_command !== 3'd4) begin
            tests_failed++;
            $display("FAIL t6_grant: got rdy=%b wr=%b cmd=%0d expected rdy=010 wr=1 cmd=4",
                     req_ready, cache_write, cache_command);
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (done_valid !== 1'b1 || done_id !== 2'd1 || done_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL t6_done: got dv=%b id=%0d err=%b expected dv=1 id=1 err=0",
                     done_valid, done_id, done_err);
        end
        $display("[TB] grant deferred until processing fell");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority_rr();
        test_illegal_cmd();
        test_timeout();
        test_reset_mid();
        test_busy_idle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
